// File: rtl/uart_tx_param.sv
// Parametrised RS-232 style transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
// Define UART_TX_BREAK_EN to add the break_req input and the BREAK (line held low) state.
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef UART_TX_BREAK_EN
  input  logic                 break_req,
`endif
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 idle,
  output logic                 start,
  output logic                 stop,
  output logic                 frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] BRK_MIN   = BW'(DATA_BITS + 1);
  localparam logic [BW-1:0] BRK_DONE  = BW'(DATA_BITS + 2);

  logic [2:0]           state_q, state_n;
  logic [CW-1:0]        cnt_q, cnt_n;
  logic [BW-1:0]        bit_q, bit_n;
  logic [DATA_BITS-1:0] shreg_q, shreg_n;
  logic                 par_q, par_n;
  logic                 brk_q, brk_n;
  logic                 bit_end;
  logic                 tx_n, ready_n, idle_n, start_n, stop_n, done_n;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    bit_n   = bit_q;
    shreg_n = shreg_q;
    par_n   = par_q;
    brk_n   = brk_q;
    if (state_q != S_IDLE) begin
      cnt_n = bit_end ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        brk_n = 1'b0;
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          state_n = S_BREAK;
        end else
`endif
        if (tx_valid) begin
          state_n = S_START;
          shreg_n = tx_data;
          par_n   = (PARITY_MODE == 2) ? ~^tx_data : ^tx_data;
        end
      end
      S_START: begin
        if (bit_end) state_n = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_n = shreg_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_n = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_n   = '0;
            state_n = S_IDLE;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      // bit_q counts whole break periods, saturating once the minimum length is met
      S_BREAK: begin
        if (bit_end && (bit_q < BRK_DONE)) bit_n = bit_q + 1'b1;
        if (!break_req && ((bit_q == BRK_DONE) || ((bit_q == BRK_MIN) && bit_end))) begin
          state_n = S_STOP;
          cnt_n   = '0;
          bit_n   = STOP_LAST;
          brk_n   = 1'b1;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered without lag
  always_comb begin
    tx_n    = 1'b1;
    ready_n = 1'b0;
    idle_n  = 1'b0;
    start_n = 1'b0;
    stop_n  = 1'b0;
    case (state_n)
      S_IDLE: begin
        ready_n = 1'b1;
        idle_n  = 1'b1;
      end
      S_START: begin
        tx_n    = 1'b0;
        start_n = 1'b1;
      end
      S_DATA:   tx_n = shreg_n[0];
      S_PARITY: tx_n = par_n;
      S_STOP:   stop_n = 1'b1;
      S_BREAK:  tx_n = 1'b0;
      default:  tx_n = 1'b1;
    endcase
    done_n = (state_n == S_STOP) && (cnt_n == CNT_LAST) && (bit_n == STOP_LAST) && !brk_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      brk_q      <= 1'b0;
      tx         <= 1'b1;
      tx_ready   <= 1'b1;
      idle       <= 1'b1;
      start      <= 1'b0;
      stop       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      bit_q      <= bit_n;
      shreg_q    <= shreg_n;
      par_q      <= par_n;
      brk_q      <= brk_n;
      tx         <= tx_n;
      tx_ready   <= ready_n;
      idle       <= idle_n;
      start      <= start_n;
      stop       <= stop_n;
      frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameter sets, table-driven frames plus corner sequences.
// Exercises the break feature when UART_TX_BREAK_EN is defined.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid [4];
  logic [7:0] data8;
  logic [4:0] data5;
  logic       break_req;
  logic       tx_s [4];
  logic       ready_s [4];
  logic       idle_s [4];
  logic       start_s [4];
  logic       stop_s [4];
  logic       done_s [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Instances: 0 = no parity, 1 = even, 2 = odd, 3 = 5 data bits with 2 stop bits
  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .tx_data(data8), .tx_valid(tx_valid[0]), .tx_ready(ready_s[0]), .tx(tx_s[0]),
    .idle(idle_s[0]), .start(start_s[0]), .stop(stop_s[0]), .frame_done(done_s[0]));

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .break_req(1'b0),
`endif
    .tx_data(data8), .tx_valid(tx_valid[1]), .tx_ready(ready_s[1]), .tx(tx_s[1]),
    .idle(idle_s[1]), .start(start_s[1]), .stop(stop_s[1]), .frame_done(done_s[1]));

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_MODE(2)) u2 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .break_req(1'b0),
`endif
    .tx_data(data8), .tx_valid(tx_valid[2]), .tx_ready(ready_s[2]), .tx(tx_s[2]),
    .idle(idle_s[2]), .start(start_s[2]), .stop(stop_s[2]), .frame_done(done_s[2]));

  uart_tx_param #(.DATA_BITS(5), .CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_MODE(0)) u3 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .break_req(1'b0),
`endif
    .tx_data(data5), .tx_valid(tx_valid[3]), .tx_ready(ready_s[3]), .tx(tx_s[3]),
    .idle(idle_s[3]), .start(start_s[3]), .stop(stop_s[3]), .frame_done(done_s[3]));

  // bits holds the line value per bit period, first-transmitted bit in position nbits-1
  typedef struct {
    int          cfg;
    logic [8:0]  data;
    logic [11:0] bits;
    int          nbits;
    int          stops;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Called one cycle before the handshake edge; returns #1 into cycle 1 of the frame
  task automatic applyStimulus(input int cfg, input logic [8:0] data);
    checkOutput($sformatf("cfg%0d ready before handshake", cfg), ready_s[cfg], 1'b1);
    data8 = data[7:0];
    data5 = data[4:0];
    tx_valid[cfg] = 1'b1;
    @(posedge clk);
    #1;
    tx_valid[cfg] = 1'b0;
  endtask

  task automatic checkFrame(input int cfg, input logic [11:0] bits, input int nbits, input int stops);
    int n;
    n = nbits * 4;
    for (int k = 1; k <= n; k++) begin
      checkOutput($sformatf("cfg%0d tx c%0d", cfg, k), tx_s[cfg], bits[nbits - 1 - (k - 1) / 4]);
      checkOutput($sformatf("cfg%0d start c%0d", cfg, k), start_s[cfg], k <= 4);
      checkOutput($sformatf("cfg%0d stop c%0d", cfg, k), stop_s[cfg], k > n - 4 * stops);
      checkOutput($sformatf("cfg%0d frame_done c%0d", cfg, k), done_s[cfg], k == n);
      checkOutput($sformatf("cfg%0d ready c%0d", cfg, k), ready_s[cfg], 1'b0);
      checkOutput($sformatf("cfg%0d idle c%0d", cfg, k), idle_s[cfg], 1'b0);
      @(posedge clk);
      #1;
    end
    checkOutput($sformatf("cfg%0d ready after frame", cfg), ready_s[cfg], 1'b1);
    checkOutput($sformatf("cfg%0d idle after frame", cfg), idle_s[cfg], 1'b1);
    checkOutput($sformatf("cfg%0d tx after frame", cfg), tx_s[cfg], 1'b1);
    checkOutput($sformatf("cfg%0d done after frame", cfg), done_s[cfg], 1'b0);
  endtask

  initial begin
    vecs[0] = '{cfg: 0, data: 9'h0A5, bits: 12'b0000_0101_0010_11 >> 2, nbits: 10, stops: 1};
    vecs[0].bits = 12'b00_0101001011;
    vecs[1] = '{cfg: 0, data: 9'h001, bits: 12'b00_0100000001, nbits: 10, stops: 1};
    vecs[2] = '{cfg: 0, data: 9'h0FF, bits: 12'b00_0111111111, nbits: 10, stops: 1};
    vecs[3] = '{cfg: 1, data: 9'h0A5, bits: 12'b0_01010010101, nbits: 11, stops: 1};
    vecs[4] = '{cfg: 2, data: 9'h0A5, bits: 12'b0_01010010111, nbits: 11, stops: 1};
    vecs[5] = '{cfg: 1, data: 9'h001, bits: 12'b0_01000000011, nbits: 11, stops: 1};
    vecs[6] = '{cfg: 2, data: 9'h001, bits: 12'b0_01000000001, nbits: 11, stops: 1};
    vecs[7] = '{cfg: 3, data: 9'h013, bits: 12'b0000_01100111, nbits: 8, stops: 2};

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) tx_valid[i] = 1'b0;
    data8 = '0;
    data5 = '0;
    break_req = 1'b0;
    #12;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("cfg%0d reset tx", i), tx_s[i], 1'b1);
      checkOutput($sformatf("cfg%0d reset ready", i), ready_s[i], 1'b1);
      checkOutput($sformatf("cfg%0d reset idle", i), idle_s[i], 1'b1);
      checkOutput($sformatf("cfg%0d reset start", i), start_s[i], 1'b0);
      checkOutput($sformatf("cfg%0d reset stop", i), stop_s[i], 1'b0);
      checkOutput($sformatf("cfg%0d reset done", i), done_s[i], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].cfg, vecs[v].data);
      checkFrame(vecs[v].cfg, vecs[v].bits, vecs[v].nbits, vecs[v].stops);
      @(posedge clk);
      #1;
    end

    // Back-to-back: tx_valid held, data changed while the first frame is in flight
    $display("[TB] back-to-back frames");
    data8 = 8'h11;
    tx_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    data8 = 8'h22;
    checkFrame(0, 12'b00_0100010001, 10, 1);
    @(posedge clk);
    #1;
    tx_valid[0] = 1'b0;
    checkFrame(0, 12'b00_0010001001, 10, 1);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of the data bits
    $display("[TB] reset mid-frame");
    applyStimulus(0, 9'h0FF);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("busy before reset idle", idle_s[0], 1'b0);
    checkOutput("busy before reset ready", ready_s[0], 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset tx", tx_s[0], 1'b1);
    checkOutput("async reset idle", idle_s[0], 1'b1);
    checkOutput("async reset ready", ready_s[0], 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, 9'h0A5);
    checkFrame(0, 12'b00_0101001011, 10, 1);
    @(posedge clk);
    #1;

`ifdef UART_TX_BREAK_EN
    // Break request with a competing tx_valid on the same edge
    $display("[TB] break sequence");
    data8 = 8'h5A;
    break_req = 1'b1;
    tx_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 6) break_req = 1'b0;
      checkOutput($sformatf("break tx c%0d", k), tx_s[0], 1'b0);
      checkOutput($sformatf("break ready c%0d", k), ready_s[0], 1'b0);
      checkOutput($sformatf("break idle c%0d", k), idle_s[0], 1'b0);
      checkOutput($sformatf("break start c%0d", k), start_s[0], 1'b0);
      checkOutput($sformatf("break stop c%0d", k), stop_s[0], 1'b0);
      @(posedge clk);
      #1;
    end
    tx_valid[0] = 1'b0;
    for (int k = 41; k <= 44; k++) begin
      checkOutput($sformatf("break tail tx c%0d", k), tx_s[0], 1'b1);
      checkOutput($sformatf("break tail stop c%0d", k), stop_s[0], 1'b1);
      checkOutput($sformatf("break tail done c%0d", k), done_s[0], 1'b0);
      checkOutput($sformatf("break tail ready c%0d", k), ready_s[0], 1'b0);
      @(posedge clk);
      #1;
    end
    checkOutput("after break idle", idle_s[0], 1'b1);
    checkOutput("after break ready", ready_s[0], 1'b1);
    checkOutput("after break tx", tx_s[0], 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised asynchronous serial (RS-232 style) transmitter, the successor to the fixed 8-bit single-shot transmitter.
- Serialises one DATA_BITS-wide word per frame: start bit, data LSB first, optional parity bit, 1 or 2 stop bits.
- Each bit is held for CLKS_PER_BIT clocks. Words are accepted through a valid/ready handshake, so frames can follow each other continuously.
- Sits between the system-side byte producer and the line driver (RS-232/RS-422 PHY).

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9.
- CLKS_PER_BIT, 16, clock cycles per bit period; legal >= 2.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  DATA_BITS  word to send; sampled only on handshake.
- tx_valid  in  1  producer has a word.
- tx_ready  out  1  block can accept a word (high only in IDLE).
- tx  out  1  serial line; idle/mark = 1.
- idle  out  1  high while in IDLE.
- start  out  1  high for the whole start-bit period.
- stop  out  1  high for the whole stop-bit period(s).
- frame_done  out  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Interface: one clock (clk), asynchronous active-low reset (rst_n).
- Reset (async assert, sync release), all outputs registered:
  - state=IDLE, tx=1, tx_ready=1, idle=1, start=0, stop=0, frame_done=0.
  - Bit counter and baud counter cleared.
- States: IDLE -> START -> DATA -> PARITY (only if PARITY_MODE != 0) -> STOP -> IDLE.
- Handshake:
  - A transfer occurs on the edge where tx_valid && tx_ready.
  - tx_data is latched into a shift register and the parity bit is computed from the latched value.
  - The next cycle enters START: tx=0, start=1, idle=0, tx_ready=0.
  - tx_valid while tx_ready=0 is ignored; no data is captured. The producer must hold tx_valid.
- Baud timing:
  - The baud counter counts 0..CLKS_PER_BIT-1 in each bit state.
  - The state/bit advances when the counter reaches CLKS_PER_BIT-1, and the counter then wraps to 0.
- DATA: tx = shreg[0]; shift right once per bit period; bit index runs 0..DATA_BITS-1, then exits.
- PARITY:
  - Even mode: tx = XOR of data (total ones, including parity, is even).
  - Odd mode: tx = inverted XOR.
- STOP:
  - tx=1, stop=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - frame_done pulses on the final cycle; the next cycle is IDLE with tx_ready=1.
- Frame length: (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Back-to-back frames: at least 1 IDLE cycle (tx=1) between the last stop cycle and the next start bit.
- Status exclusivity: exactly one of idle/start/stop/(data or parity) is active at a time; start and stop are never high together.
- Reset mid-frame: line returns to 1 immediately; the partial frame is abandoned and not resumed.
- Word width: tx_data bits above DATA_BITS do not exist; the shift register is exactly DATA_BITS wide.

Optional Feature:
- UART_TX_BREAK_EN defined: adds input port break_req (1 bit) and state BREAK.
  - break_req sampled high in IDLE enters BREAK. Break has priority over tx_valid on the same edge.
  - In BREAK: tx=0, tx_ready=0, idle=0, start=0, stop=0, for as long as break_req stays high, minimum (DATA_BITS+2)*CLKS_PER_BIT cycles.
  - Exit goes to STOP for one bit period (tx=1, stop=1), then IDLE. No frame_done pulse for a break.
  - break_req outside IDLE is ignored until IDLE.
- Not defined: no break_req port, no BREAK state; behaviour otherwise identical.

Test Plan:
- Defaults with CLKS_PER_BIT=4, PARITY_MODE=0, send 0xA5:
  - tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total).
  - start high for cycles 1-4 after handshake, stop high for cycles 37-40, frame_done on cycle 40, tx_ready back high on cycle 41.
- PARITY_MODE=1 then 2, send 0xA5 (four ones): parity bit 0 (even), 1 (odd); frame 44 cycles. Send 0x01: parity 1 (even), 0 (odd).
- DATA_BITS=5, STOP_BITS=2, CLKS_PER_BIT=4, send 5'b10011: tx = 0,1,1,0,0,1,1,1; frame 32 cycles; stop high for 8 cycles.
- tx_valid held continuously, words 0x11 then 0x22: exactly one IDLE cycle between frames; second word captured only when tx_ready=1; tx_data changes while busy do not alter the frame in flight.
- rst_n pulsed low mid-DATA of 0xFF: tx=1, idle=1, tx_ready=1 immediately (async); next tx_valid starts a clean frame with the correct start bit.
- UART_TX_BREAK_EN, break_req high for 5 cycles with CLKS_PER_BIT=4, DATA_BITS=8:
  - tx low for exactly 40 cycles, then tx=1 with stop=1 for 4 cycles, then IDLE.
  - tx_valid during the break is not accepted.
